// File: rtl/pbe_pkg.sv
// Shared types and helpers for the sequential priority binary encoder.
// Imported by pbe_stream and its least-significant-one encoder.
package pbe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index width for an n-bit request vector; never below one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pbe_stream_lsb_index_enc.sv
// Combinational least-significant-one encoder: mirror image of the one-hot decoder.
// Reports the lowest set index, whether any bit is set, and whether exactly one is set.
module lsb_index_enc
  import pbe_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          single
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] rest;

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  always_comb begin
    rest   = vec & (vec - ONE);
    any    = |vec;
    single = any && (rest == '0);
  end

endmodule

// File: rtl/pbe_stream.sv
// Sequential priority binary encoder: accepts a request mask and streams the index
// of every set bit, lowest first, one per output handshake.
//
// state | meaning
// IDLE  | ready for a new mask; all-zero masks are dropped with a zero_drop pulse
// EMIT  | presenting the lowest pending index until the consumer takes it
module pbe_stream
  import pbe_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          zero_drop
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [N-1:0] pending, pending_nxt;
  logic         zero_drop_nxt;

  logic [IW-1:0] enc_idx;
  logic          enc_any;
  logic          enc_single;

  lsb_index_enc #(.N(N)) u_enc (
    .vec    (pending),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      zero_drop <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      zero_drop <= zero_drop_nxt;
    end
  end

  // Clearing the lowest set bit is the same as clearing the bit at enc_idx.
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    zero_drop_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_nxt = in_vec;
            state_nxt   = EMIT;
          end else begin
            zero_drop_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (!enc_any) begin
          state_nxt = IDLE;
        end else if (out_ready) begin
          pending_nxt = pending & (pending - ONE);
          if (enc_single) begin
            pending_nxt = '0;
            state_nxt   = IDLE;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == EMIT);
    out_idx   = enc_idx;
    out_last  = enc_single;
  end

endmodule

// File: tb/tb_pbe_stream.sv
// Directed self-checking bench for pbe_stream with N=8.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_pbe_stream;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          zero_drop;

  int n_cmp = 0;
  int n_err = 0;

  pbe_stream #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_drop (zero_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
      n_cmp++;
      if ({out_valid, out_idx, in_ready, zero_drop, out_last} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_hold: got v=%b idx=%0d rdy=%b zd=%b last=%b, need v=0 idx=0 rdy=1 zd=0 last=0",
                 out_valid, out_idx, in_ready, zero_drop, out_last);
      end
    end
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    step();
    n_cmp++;
    if ({out_valid, out_idx, in_ready, zero_drop, out_last} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release: got v=%b idx=%0d rdy=%b zd=%b last=%b, need v=0 idx=0 rdy=1 zd=0 last=0",
               out_valid, out_idx, in_ready, zero_drop, out_last);
    end
  endtask

  task automatic test_single_bit();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 8'b0000_0100;
    step();
    in_valid = 1'b0;
    in_vec   = '0;
    n_cmp++;
    if ({out_valid, out_idx, out_last, in_ready} !== {1'b1, 3'd2, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_beat: got v=%b idx=%0d last=%b rdy=%b, need v=1 idx=2 last=1 rdy=0",
               out_valid, out_idx, out_last, in_ready);
    end
    step();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL single_done: got v=%b rdy=%b, need v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] exp_idx [3] = '{3'd0, 3'd5, 3'd7};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 8'b1010_0001;
    step();
    in_valid = 1'b0;
    in_vec   = '0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({out_valid, out_idx, out_last} !== {1'b1, 3'd0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b idx=%0d last=%b, need v=1 idx=0 last=0",
                 i, out_valid, out_idx, out_last);
      end
      step();
    end
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      n_cmp++;
      if ({out_valid, out_idx, out_last} !== {1'b1, exp_idx[b], (b == 2)}) begin
        n_err++;
        $display("FAIL bp_beat[%0d]: got v=%b idx=%0d last=%b, need v=1 idx=%0d last=%b",
                 b, out_valid, out_idx, out_last, exp_idx[b], (b == 2));
      end
      step();
    end
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_done: got v=%b rdy=%b, need v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_mask();
    in_valid = 1'b1;
    in_vec   = '0;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({zero_drop, out_valid, in_ready} !== 3'b101) begin
      n_err++;
      $display("FAIL zero_pulse: got zd=%b v=%b rdy=%b, need zd=1 v=0 rdy=1", zero_drop, out_valid, in_ready);
    end
    step();
    n_cmp++;
    if ({zero_drop, out_valid, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL zero_after: got zd=%b v=%b rdy=%b, need zd=0 v=0 rdy=1", zero_drop, out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 8'hFF;
    step();
    in_valid = 1'b0;
    in_vec   = '0;
    for (int b = 0; b < N; b++) begin
      n_cmp++;
      if ({out_valid, out_idx, out_last} !== {1'b1, 3'(b), (b == N - 1)}) begin
        n_err++;
        $display("FAIL full_beat[%0d]: got v=%b idx=%0d last=%b, need v=1 idx=%0d last=%b",
                 b, out_valid, out_idx, out_last, b, (b == N - 1));
      end
      if (b == N - 1) begin
        in_valid = 1'b1;
        in_vec   = 8'b0000_0011;
      end
      step();
    end
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_gap: got v=%b rdy=%b, need v=0 rdy=1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    in_vec   = '0;
    n_cmp++;
    if ({out_valid, out_idx, out_last} !== {1'b1, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_accept: got v=%b idx=%0d last=%b, need v=1 idx=0 last=0", out_valid, out_idx, out_last);
    end
    step();
    n_cmp++;
    if ({out_valid, out_idx, out_last} !== {1'b1, 3'd1, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_second: got v=%b idx=%0d last=%b, need v=1 idx=1 last=1", out_valid, out_idx, out_last);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 8'hF0;
    step();
    in_valid = 1'b0;
    in_vec   = '0;
    n_cmp++;
    if ({out_valid, out_idx} !== {1'b1, 3'd4}) begin
      n_err++;
      $display("FAIL mid_first: got v=%b idx=%0d, need v=1 idx=4", out_valid, out_idx);
    end
    step();
    n_cmp++;
    if ({out_valid, out_idx} !== {1'b1, 3'd5}) begin
      n_err++;
      $display("FAIL mid_five: got v=%b idx=%0d, need v=1 idx=5", out_valid, out_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_idx, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL mid_async: got v=%b idx=%0d rdy=%b, need v=0 idx=0 rdy=1", out_valid, out_idx, in_ready);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL mid_after[%0d]: got v=%b idx=%0d rdy=%b, need v=0 rdy=1", i, out_valid, out_idx, in_ready);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_single_bit();
    test_backpressure();
    test_zero_mask();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
